// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants and state encoding for the 32-bit shared-adder sequencer.
// Revision: 1.0
`default_nettype none

package adder_share_pkg;

  localparam int HALF_W  = 16;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sixteen_bit_adder.sv
// sixteen_bit_adder: 16-bit adder with carry in and carry out.
// Revision: 1.0
`default_nettype none

module sixteen_bit_adder (
  output logic        Cout,
  output logic [15:0] S,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {16'd0, Cin};

endmodule

`default_nettype wire

// File: rtl/adder_share_seq.sv
// adder_share_seq: round-robin two-requester 32-bit add/sub over two passes of one 16-bit adder.
// Revision: 1.0
`default_nettype none

module adder_share_seq
  import adder_share_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_A,
  input  logic [W-1:0] req0_B,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_A,
  input  logic [W-1:0] req1_B,
  input  logic         req1_sub,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_S,
  output logic         resp_Cout,
  output logic         resp_V,
  output logic         resp_id
);

  state_t               state, state_nxt;
  logic [W-1:0]         a_r, b_r;
  logic                 c_r;
  logic                 id_r;
  logic                 prio;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;

  logic [HALF_W-1:0]    add_a, add_b, add_s;
  logic                 add_cout;
  logic                 hi_pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) grant = prio ? 2'b10 : 2'b01;
        else                          grant = {req1_valid, req0_valid};
        if (|grant) state_nxt = LOW;
      end
      LOW:     state_nxt = HIGH;
      HIGH:    state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = |grant;
  // Gate with rst_n so no grant is visible while reset is held.
  assign req0_ready = rst_n & grant[0];
  assign req1_ready = rst_n & grant[1];
  assign resp_valid = (state == DONE);

  assign hi_pass = (state == HIGH);
  assign add_a   = hi_pass ? a_r[W-1:HALF_W] : a_r[HALF_W-1:0];
  assign add_b   = hi_pass ? b_r[W-1:HALF_W] : b_r[HALF_W-1:0];

  sixteen_bit_adder u_adder (
    .Cout (add_cout),
    .S    (add_s),
    .A    (add_a),
    .B    (add_b),
    .Cin  (c_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= 1'b0;
      id_r      <= 1'b0;
      prio      <= 1'b0;
      resp_S    <= '0;
      resp_Cout <= 1'b0;
      resp_V    <= 1'b0;
      resp_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtract is folded into the operands: A + ~B with carry-in 1.
            a_r  <= grant[1] ? req1_A : req0_A;
            if (grant[1]) b_r <= req1_sub ? ~req1_B : req1_B;
            else          b_r <= req0_sub ? ~req0_B : req0_B;
            c_r  <= grant[1] ? req1_sub : req0_sub;
            id_r <= grant[1];
            prio <= ~grant[1];
          end
        end
        LOW: begin
          resp_S[HALF_W-1:0] <= add_s;
          c_r                <= add_cout;
        end
        HIGH: begin
          resp_S[W-1:HALF_W] <= add_s;
          resp_Cout          <= add_cout;
          resp_V             <= (a_r[W-1] == b_r[W-1]) && (add_s[HALF_W-1] != a_r[W-1]);
          resp_id            <= id_r;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_share_seq.sv
// tb_adder_share_seq: directed and randomized checks of adder_share_seq against an arithmetic model.
// Revision: 1.0
`default_nettype none

module tb_adder_share_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_S;
  logic        resp_Cout, resp_V, resp_id;

  adder_share_seq #(.W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .req1_sub   (req1_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_S     (resp_S),
    .resp_Cout  (resp_Cout),
    .resp_V     (resp_V),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit prefer = 1'b0;
  int acc_cyc = 0;
  int last_id = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: true 33-bit unsigned result for carry, signed range test for overflow.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                output logic [31:0] s, output bit c, output bit v);
    logic [32:0] w;
    longint r;
    if (sub) begin
      w = {1'b0, a} + {1'b0, ~b} + 33'd1;
      r = longint'($signed(a)) - longint'($signed(b));
    end else begin
      w = {1'b0, a} + {1'b0, b};
      r = longint'($signed(a)) + longint'($signed(b));
    end
    s = w[31:0];
    c = w[32];
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic run_op(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                        input logic [31:0] a1, input logic [31:0] b1, input bit s1,
                        input int stall, input bit keep);
    int g;
    int w;
    logic [31:0] ea, eb, es_sum;
    bit esub, ec, ev;
    @(negedge clk);
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_sub = s0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_sub = s1;
    resp_ready = (stall == 0);
    #1;
    w = 0;
    while (!(req0_ready || req1_ready) && w < 8) begin
      @(negedge clk); #1; w++;
    end
    chk("grant_wait", w, 0);
    if (w == 8) return;
    g = (v0 && v1) ? int'(prefer) : (v1 ? 1 : 0);
    chk("ready0", req0_ready, (g == 0));
    chk("ready1", req1_ready, (g == 1));
    prefer = (g == 0);
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    esub = (g == 1) ? s1 : s0;
    model(ea, eb, esub, es_sum, ec, ev);
    acc_cyc = cyc;

    @(negedge clk);
    if (!keep) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_A = $urandom; req0_B = $urandom; req0_sub = 1'($urandom);
      req1_A = $urandom; req1_B = $urandom; req1_sub = 1'($urandom);
    end
    #1;
    chk("low_valid", resp_valid, 0);
    chk("low_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk); #1;
    chk("high_valid", resp_valid, 0);
    chk("high_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk); #1;
    chk("done_valid", resp_valid, 1);
    chk("resp_S", resp_S, es_sum);
    chk("resp_Cout", resp_Cout, ec);
    chk("resp_V", resp_V, ev);
    chk("resp_id", resp_id, g);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      chk("stall_valid", resp_valid, 1);
      chk("stall_S", resp_S, es_sum);
      chk("stall_CV", {resp_Cout, resp_V, resp_id}, {ec, ev, g[0]});
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      if (s == stall - 1) resp_ready = 1'b1;
    end
    last_id = g;
  endtask

  initial begin
    int prev;
    int p;

    // Reset state, including suppression of ready while held in reset.
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_S", resp_S, 0);
    chk("rst_CVid", {resp_Cout, resp_V, resp_id}, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    prefer = 1'b0;

    // Directed arithmetic cases.
    run_op(1, 0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 32'h0, 0, 0, 0);
    chk("d_carry_S", resp_S, 32'h0);
    chk("d_carry_CVid", {resp_Cout, resp_V, resp_id}, 3'b100);
    run_op(0, 1, 32'h0, 32'h0, 0, 32'h0000_FFFF, 32'h1, 0, 0, 0);
    chk("d_mid_S", resp_S, 32'h0001_0000);
    chk("d_mid_CVid", {resp_Cout, resp_V, resp_id}, 3'b001);
    run_op(1, 0, 32'd5, 32'd7, 1, 32'h0, 32'h0, 0, 0, 0);
    chk("d_sub_S", resp_S, 32'hFFFF_FFFE);
    chk("d_sub_CV", {resp_Cout, resp_V}, 2'b00);
    run_op(0, 1, 32'h0, 32'h0, 0, 32'h8000_0000, 32'h1, 1, 0, 0);
    chk("d_subov_S", resp_S, 32'h7FFF_FFFF);
    chk("d_subov_CV", {resp_Cout, resp_V}, 2'b11);

    // Backpressure: 5 stall cycles in DONE with both requesters waiting.
    run_op(1, 1, 32'h1234_5678, 32'h0F0F_0F0F, 0, 32'h7FFF_FFFF, 32'h1, 0, 5, 1);
    prev = acc_cyc;
    run_op(1, 1, 32'hAAAA_0000, 32'h5555_FFFF, 1, 32'hDEAD_BEEF, 32'h1111_1111, 1, 0, 0);
    chk("stall_spacing", acc_cyc - prev, 9);

    // Randomized operations against the model.
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(1, 3));
      run_op(p[0], p[1], $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom),
             int'($urandom_range(0, 2)), 0);
    end

    // Arbitration from reset: both requesters continuously valid.
    @(negedge clk);
    rst_n = 1'b0;
    prefer = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_op(1, 1, 32'h100 + k, 32'h3, 0, 32'h200 + k, 32'h5, 1, 0, 1);
      chk("arb_id", resp_id, k % 2);
      if (k > 0) chk("arb_spacing", acc_cyc - prev, 4);
      prev = acc_cyc;
    end

    // Reset in the HIGH pass discards the operation.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_A = 32'h0001_2345; req0_B = 32'h0000_1111; req0_sub = 1'b0;
    #1;
    chk("mid_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_S", resp_S, 0);
    chk("mid_rst_CVid", {resp_Cout, resp_V, resp_id}, 0);
    chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
    prefer = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mid_no_resp", resp_valid, 0);
    end
    run_op(1, 1, 32'd3, 32'd4, 0, 32'd9, 32'd9, 1, 0, 0);
    chk("post_rst_S", resp_S, 32'd7);
    chk("post_rst_id", resp_id, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
